// File: rtl/imm_split_encoder.sv
// imm_split_encoder: packs 32-bit constants into one or two 18-bit immediate beats.
// Saturating beat statistics are built only when IMM_STATS_EN is defined.
module imm_split_encoder (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_value,
  input  logic        in_u,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [17:0] out_imm,
  output logic [1:0]  out_kind,
  output logic        out_u,
  output logic        out_last,
  output logic [15:0] stat_single,
  output logic [15:0] stat_split
);

  typedef enum logic [1:0] {StIdle, StSingle, StHigh, StLow} state_e;

  state_e      r_state;
  state_e      w_state_d;
  logic [31:0] r_value;
  logic        r_u;
  logic        w_fit;
  logic        w_accept;
  logic        w_out_hs;

  assign w_fit    = in_u ? (in_value[31:18] == 14'd0)
                         : (in_value[31:18] == {14{in_value[17]}});
  assign w_out_hs = out_valid & out_ready;
  // A final-beat handshake frees the block, so a new constant can be taken that same cycle.
  assign in_ready = (r_state == StIdle) | (w_out_hs & out_last);
  assign w_accept = in_valid & in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= StIdle;
      r_value <= '0;
      r_u     <= 1'b0;
    end else begin
      r_state <= w_state_d;
      if (w_accept) begin
        r_value <= in_value;
        r_u     <= in_u;
      end
    end
  end

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle:          if (w_accept) w_state_d = w_fit ? StSingle : StHigh;
      StHigh:          if (out_ready) w_state_d = StLow;
      StSingle, StLow: if (out_ready) w_state_d = w_accept ? (w_fit ? StSingle : StHigh) : StIdle;
      default:         w_state_d = StIdle;
    endcase
  end

  always_comb begin
    out_valid = 1'b1;
    out_kind  = 2'b00;
    out_imm   = r_value[17:0];
    out_u     = 1'b1;
    out_last  = 1'b1;
    unique case (r_state)
      StIdle: begin
        out_valid = 1'b0;
        out_imm   = '0;
        out_u     = 1'b0;
        out_last  = 1'b0;
      end
      StSingle: out_u = r_u;
      StHigh: begin
        out_kind = 2'b01;
        out_imm  = {4'b0000, r_value[31:18]};
        out_last = 1'b0;
      end
      StLow:   out_kind = 2'b10;
      default: out_valid = 1'b0;
    endcase
  end

`ifdef IMM_STATS_EN
  logic [15:0] r_stat_single;
  logic [15:0] r_stat_split;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stat_single <= '0;
      r_stat_split  <= '0;
    end else begin
      if (w_out_hs && (r_state == StSingle) && (r_stat_single != 16'hFFFF)) begin
        r_stat_single <= r_stat_single + 16'd1;
      end
      if (w_out_hs && (r_state == StLow) && (r_stat_split != 16'hFFFF)) begin
        r_stat_split <= r_stat_split + 16'd1;
      end
    end
  end

  assign stat_single = r_stat_single;
  assign stat_split  = r_stat_split;
`else
  assign stat_single = '0;
  assign stat_split  = '0;
`endif

endmodule
